// File: rtl/apb_ram_slave_if.sv
// rtl/apb_ram_slave_if.sv - APB-style bus bundle between an initiator and apb_ram_slave
interface apb_ram_slave_if;
  logic [7:0]  paddr;
  logic        wr_en;
  logic        psel;
  logic        pen;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pselverr;

  modport master (
    output paddr, wr_en, psel, pen, pwdata,
    input  prdata, pready, pselverr
  );

  modport slave (
    input  paddr, wr_en, psel, pen, pwdata,
    output prdata, pready, pselverr
  );
endinterface

// File: rtl/apb_ram_slave.sv
// rtl/apb_ram_slave.sv - APB word RAM slave, DEPTH x 32; APB_RAM_WAIT_STATE_EN adds one WAIT cycle before ACCESS
module apb_ram_slave #(
  parameter int DEPTH = 64
) (
  input logic            clk,
  input logic            rst,
  apb_ram_slave_if.slave bus
);
  localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] LIMIT = 9'(DEPTH);

`ifdef APB_RAM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
`endif

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic          in_range;
  logic          req;
  logic          do_write;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  // Full 8-bit compare so out-of-range addresses never alias into the array.
  assign in_range = {1'b0, bus.paddr} < LIMIT;
  assign idx      = bus.paddr[AW-1:0];
  assign req      = bus.psel & bus.pen;
  assign rd_word  = (in_range && !bus.wr_en) ? mem[idx] : 32'h0;
  assign do_write = (state == ACCESS) && req && bus.wr_en && in_range && !rst;

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= bus.pwdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.prdata   <= 32'h0;
      bus.pready   <= 1'b0;
      bus.pselverr <= 1'b0;
    end else begin
      bus.pready   <= 1'b0;
      bus.pselverr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.psel) state <= SETUP;
        end
        SETUP: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.pen) begin
`ifdef APB_RAM_WAIT_STATE_EN
            state <= WAIT;
`else
            state        <= ACCESS;
            bus.pready   <= 1'b1;
            bus.pselverr <= !in_range;
            bus.prdata   <= rd_word;
`endif
          end
        end
`ifdef APB_RAM_WAIT_STATE_EN
        WAIT: begin
          if (req) begin
            state        <= ACCESS;
            bus.pready   <= 1'b1;
            bus.pselverr <= !in_range;
            bus.prdata   <= rd_word;
          end else begin
            state <= IDLE;
          end
        end
`endif
        // Dropping only pen lets the initiator start the next transfer straight from SETUP.
        ACCESS: begin
          state <= (bus.psel && !bus.pen) ? SETUP : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_ram_slave.sv
// tb/tb_apb_ram_slave.sv - directed self-checking bench for apb_ram_slave
module tb_apb_ram_slave;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  apb_ram_slave_if bus ();

  apb_ram_slave #(.DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef APB_RAM_WAIT_STATE_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  localparam int M_DONE  = 0;
  localparam int M_ABORT = 1;
  localparam int M_RESET = 2;
  localparam int M_B2B   = 3;
  localparam int M_RESET_UP = 4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transfer driven and sampled on falling edges; mode selects how the ACCESS cycle ends.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input int mode, output logic [31:0] rd, output logic err);
    int lat;
    @(negedge clk);
    bus.psel   = 1'b1;
    bus.pen    = 1'b0;
    bus.wr_en  = wr;
    bus.paddr  = addr;
    bus.pwdata = data;
    @(negedge clk);
    bus.pen = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.pready && lat < 8);
    check_val("pready_seen", {31'h0, bus.pready}, 32'h1);
    check_val("latency", lat + 1, EXP_LAT);
    rd  = bus.prdata;
    err = bus.pselverr;
    case (mode)
      M_ABORT: begin
        bus.psel = 1'b0;
        bus.pen  = 1'b0;
      end
      M_RESET: rst = 1'b1;
      M_RESET_UP: begin
        bus.pen = 1'b0;
        @(negedge clk);
        check_val("pready_drop", {31'h0, bus.pready}, 32'h0);
        bus.pen = 1'b1;
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!bus.pready && lat < 8);
        check_val("reaccess_lat", lat, EXP_LAT - 1);
        rd  = bus.prdata;
        err = bus.pselverr;
      end
      default: ;
    endcase
    @(negedge clk);
    check_val("pready_pulse", {31'h0, bus.pready}, 32'h0);
    if (mode == M_RESET) begin
      check_val("rst_prdata", bus.prdata, 32'h0);
      check_val("rst_pselverr", {31'h0, bus.pselverr}, 32'h0);
      rst = 1'b0;
    end
    if (mode == M_B2B) begin
      bus.pen = 1'b0;
    end else begin
      bus.psel = 1'b0;
      bus.pen  = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bus.psel   = 1'b0;
    bus.pen    = 1'b0;
    bus.wr_en  = 1'b0;
    bus.paddr  = 8'h0;
    bus.pwdata = 32'h0;
    repeat (2) @(negedge clk);
    check_val("reset_pready", {31'h0, bus.pready}, 32'h0);
    check_val("reset_pselverr", {31'h0, bus.pselverr}, 32'h0);
    check_val("reset_prdata", bus.prdata, 32'h0);
    rst = 1'b0;

    xfer(1'b1, 8'h05, 32'hDEADBEEF, M_DONE, rd, err);
    check_val("wr05_err", {31'h0, err}, 32'h0);
    check_val("wr05_prdata", rd, 32'h0);
    xfer(1'b0, 8'h05, 32'h0, M_DONE, rd, err);
    check_val("rd05_data", rd, 32'hDEADBEEF);
    check_val("rd05_err", {31'h0, err}, 32'h0);

    xfer(1'b1, 8'd63, 32'h12345678, M_DONE, rd, err);
    check_val("wr63_err", {31'h0, err}, 32'h0);
    xfer(1'b0, 8'd63, 32'h0, M_DONE, rd, err);
    check_val("rd63_data", rd, 32'h12345678);

    xfer(1'b1, 8'd0, 32'h0BADF00D, M_DONE, rd, err);
    xfer(1'b1, 8'd64, 32'hCAFEF00D, M_DONE, rd, err);
    check_val("wr64_err", {31'h0, err}, 32'h1);
    xfer(1'b1, 8'd128, 32'h55AA55AA, M_DONE, rd, err);
    check_val("wr128_err", {31'h0, err}, 32'h1);
    xfer(1'b0, 8'd64, 32'h0, M_DONE, rd, err);
    check_val("rd64_data", rd, 32'h0);
    check_val("rd64_err", {31'h0, err}, 32'h1);
    xfer(1'b0, 8'd255, 32'h0, M_DONE, rd, err);
    check_val("rd255_err", {31'h0, err}, 32'h1);
    xfer(1'b0, 8'd0, 32'h0, M_DONE, rd, err);
    check_val("rd00_noalias", rd, 32'h0BADF00D);
    check_val("rd00_err", {31'h0, err}, 32'h0);

    xfer(1'b1, 8'h10, 32'h11111111, M_DONE, rd, err);
    xfer(1'b1, 8'h10, 32'hAAAA5555, M_ABORT, rd, err);
    xfer(1'b0, 8'h10, 32'h0, M_DONE, rd, err);
    check_val("abort_keep10", rd, 32'h11111111);

    xfer(1'b1, 8'h01, 32'h00000001, M_B2B, rd, err);
    xfer(1'b0, 8'h01, 32'h0, M_DONE, rd, err);
    check_val("b2b_rd01", rd, 32'h00000001);

    xfer(1'b1, 8'h02, 32'h22222222, M_DONE, rd, err);
    xfer(1'b1, 8'h02, 32'hFFFF0000, M_RESET, rd, err);
    xfer(1'b0, 8'h02, 32'h0, M_DONE, rd, err);
    check_val("rst_nowrite02", rd, 32'h22222222);
    xfer(1'b0, 8'h05, 32'h0, M_DONE, rd, err);
    check_val("rst_keep05", rd, 32'hDEADBEEF);

    xfer(1'b0, 8'd63, 32'h0, M_RESET_UP, rd, err);
    check_val("resetup_rd63", rd, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
